// File: rtl/switch_bcd_if.sv
// ============================================================================
// Module   : switch_bcd_if
// Brief    : Bus between the switch feeder and the BCD encoder.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface switch_bcd_if #(
  parameter int IN_W   = 16,
  parameter int DIGITS = 8
);
  logic [IN_W-1:0]     sw_in;
  logic                start;
  logic [4*DIGITS-1:0] bcd_out;
  logic                busy;
  logic                done;

  modport master (
    output sw_in,
    output start,
    input  bcd_out,
    input  busy,
    input  done
  );

  modport slave (
    input  sw_in,
    input  start,
    output bcd_out,
    output busy,
    output done
  );
endinterface

`default_nettype wire

// File: rtl/switch_bcd_encoder.sv
// ============================================================================
// Module   : switch_bcd_encoder
// Brief    : Synchronised switch value -> packed BCD via iterative double-dabble.
//            Optional LEADING_ZERO_BLANK_EN blanks leading zero digits.
// Revision : 1.0
// ============================================================================
`default_nettype none

module switch_bcd_encoder #(
  parameter int         IN_W       = 16,
  parameter int         DIGITS     = 8,
  parameter logic [3:0] BLANK_CODE = 4'hF
) (
  input  logic       clk,
  input  logic       rst_n,
  switch_bcd_if.slave bus
);

  localparam int W     = 4 * DIGITS;
  localparam int CNT_W = $clog2(IN_W + 1);

  // 10^DIGITS > 2^IN_W  <=>  DIGITS*log2(10) > IN_W (never equal for integers)
  localparam longint LHS = longint'(DIGITS) * 64'd33219;
  localparam longint RHS = longint'(IN_W) * 64'd10000;

  if (LHS <= RHS) begin : g_digits_check
    $error("switch_bcd_encoder: DIGITS too small for IN_W");
  end
  if (BLANK_CODE < 4'hA) begin : g_blank_check
    $error("switch_bcd_encoder: BLANK_CODE must not be a decimal digit");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q;
  logic [IN_W-1:0]  sync1_q, sync2_q, src_q, bin_q;
  logic [W-1:0]     scratch_q, scratch_d, bcd_q, bcd_d;
  logic [W-1:0]     scratch_adj;
  logic [CNT_W-1:0] cnt_q;
  logic             done_q;
  logic [3:0]       nib;

  always_comb begin
    scratch_adj = '0;
    nib         = '0;
    for (int i = 0; i < DIGITS; i++) begin
      nib = scratch_q[4*i +: 4];
      if (nib >= 4'd5) nib = nib + 4'd3;
      scratch_adj[4*i +: 4] = nib;
    end
    scratch_d = {scratch_adj[W-2:0], bin_q[IN_W-1]};
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic seen_nz;
  // Walk down from the top digit; everything before the first nonzero is blank.
  always_comb begin
    bcd_d   = scratch_q;
    seen_nz = 1'b0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (scratch_q[4*i +: 4] != 4'd0) seen_nz = 1'b1;
      if (!seen_nz) bcd_d[4*i +: 4] = BLANK_CODE;
    end
  end
`else
  assign bcd_d = scratch_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      src_q     <= '0;
      bin_q     <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      done_q    <= 1'b0;
      state_q   <= S_IDLE;
    end else begin
      sync1_q <= bus.sw_in;
      sync2_q <= sync1_q;
      done_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start || (sync2_q != src_q)) begin
            bin_q     <= sync2_q;
            src_q     <= sync2_q;
            scratch_q <= '0;
            cnt_q     <= '0;
            state_q   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          scratch_q <= scratch_d;
          bin_q     <= bin_q << 1;
          cnt_q     <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(IN_W - 1)) state_q <= S_DONE;
        end
        S_DONE: begin
          bcd_q   <= bcd_d;
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.bcd_out = bcd_q;
  assign bus.busy    = (state_q != S_IDLE);
  assign bus.done    = done_q;

endmodule

`default_nettype wire

// File: tb/tb_switch_bcd_encoder.sv
// ============================================================================
// Module   : tb_switch_bcd_encoder
// Brief    : Self-checking bench: directed scenarios plus random values
//            against a decimal-arithmetic reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_switch_bcd_encoder;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  int   done_cnt;

  switch_bcd_if #(.IN_W(16), .DIGITS(8)) bus ();

  switch_bcd_encoder #(.IN_W(16), .DIGITS(8), .BLANK_CODE(4'hF)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: decimal digits by repeated division; optional leading blanking.
  function automatic logic [31:0] ref_bcd(input int unsigned v);
    logic [31:0] r;
    int unsigned rem;
    r   = '0;
    rem = v;
    for (int i = 0; i < 8; i++) begin
`ifdef LEADING_ZERO_BLANK_EN
      if (i > 0 && rem == 0) r[4*i +: 4] = 4'hF;
      else                   r[4*i +: 4] = 4'(rem % 10);
`else
      r[4*i +: 4] = 4'(rem % 10);
`endif
      rem = rem / 10;
    end
    return r;
  endfunction

  // Counts edges until done is seen; returns at posedge+1 of the done cycle.
  task automatic wait_done(input int max_cyc, output int lat, output int busy_cyc);
    logic seen;
    seen     = 1'b0;
    lat      = -1;
    busy_cyc = 0;
    for (int k = 1; k <= max_cyc && !seen; k++) begin
      @(posedge clk); #1;
      if (bus.busy === 1'b1) busy_cyc++;
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        lat  = k;
      end
    end
    check("done_seen", 64'(seen), 64'd1);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int lat, bc, d0;
    int unsigned v, prev;
    n_checks  = 0;
    n_errors  = 0;
    done_cnt  = 0;
    rst_n     = 1'b0;
    bus.sw_in = '0;
    bus.start = 1'b0;

    // 1: reset state, no spurious activity afterwards
    cycles(3);
    check("rst_bcd",  64'(bus.bcd_out), 64'd0);
    check("rst_busy", 64'(bus.busy),    64'd0);
    check("rst_done", 64'(bus.done),    64'd0);
    rst_n = 1'b1;
    cycles(50);
    check("idle_done_cnt", 64'(done_cnt), 64'd0);
    check("idle_busy",     64'(bus.busy), 64'd0);

    // 2: switch change -> 2 sync edges, detect edge, then 17 edges to done
    d0 = done_cnt;
    bus.sw_in = 16'd1234;
    wait_done(60, lat, bc);
    check("lat_1234", 64'(lat), 64'd20);
    check("bcd_1234", 64'(bus.bcd_out), 64'(ref_bcd(1234)));
    cycles(5);
    check("done_once_1234", 64'(done_cnt - d0), 64'd1);

    // 3: maximum input and busy width
    bus.sw_in = 16'hFFFF;
    wait_done(60, lat, bc);
    check("bcd_max",  64'(bus.bcd_out), 64'(ref_bcd(65535)));
    check("busy_len", 64'(bc), 64'd17);
    cycles(3);

    // 4: change and start during SHIFT do not abort; change picked up after
    d0 = done_cnt;
    bus.sw_in = 16'd100;
    cycles(8);
    check("busy_mid", 64'(bus.busy), 64'd1);
    bus.sw_in = 16'd200;
    cycles(2);
    pulse_start();
    wait_done(60, lat, bc);
    check("bcd_100", 64'(bus.bcd_out), 64'(ref_bcd(100)));
    wait_done(60, lat, bc);
    check("bcd_200", 64'(bus.bcd_out), 64'(ref_bcd(200)));
    cycles(30);
    check("done_twice", 64'(done_cnt - d0), 64'd2);

    // 5: start in IDLE reconverts an unchanged value
    bus.sw_in = 16'd42;
    wait_done(60, lat, bc);
    cycles(3);
    d0 = done_cnt;
    pulse_start();
    wait_done(60, lat, bc);
    check("lat_start", 64'(lat), 64'd17);
    check("bcd_42",    64'(bus.bcd_out), 64'(ref_bcd(42)));
    cycles(5);
    check("done_once_start", 64'(done_cnt - d0), 64'd1);

    // 6: asynchronous reset in the middle of SHIFT
    d0 = done_cnt;
    bus.sw_in = 16'd9999;
    cycles(10);
    check("busy_pre_rst", 64'(bus.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("async_bcd",  64'(bus.bcd_out), 64'd0);
    check("async_busy", 64'(bus.busy),    64'd0);
    cycles(3);
    check("no_done_rst", 64'(done_cnt - d0), 64'd0);
    rst_n = 1'b1;
    wait_done(60, lat, bc);
    check("lat_9999", 64'(lat), 64'd20);
    check("bcd_9999", 64'(bus.bcd_out), 64'(ref_bcd(9999)));
    cycles(3);

    // 7: start coincident with a detected change gives a single conversion
    d0 = done_cnt;
    bus.sw_in = 16'd7;
    cycles(2);
    pulse_start();
    wait_done(60, lat, bc);
    check("bcd_7", 64'(bus.bcd_out), 64'(ref_bcd(7)));
    cycles(30);
    check("done_once_combo", 64'(done_cnt - d0), 64'd1);

    // 8: zero, then random values (start used when the value repeats)
    prev = 7;
    for (int it = 0; it < 24; it++) begin
      if (it == 0)      v = 0;
      else if (it == 1) v = 65535;
      else              v = $urandom_range(0, 65535);
      if (v % 5 == 0) v = v / 1000;
      bus.sw_in = 16'(v);
      if (v == prev) pulse_start();
      wait_done(60, lat, bc);
      check("bcd_rand", 64'(bus.bcd_out), 64'(ref_bcd(v)));
      prev = v;
      cycles($urandom_range(1, 4));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
